matmul_output_deskew: RTL and testbench

Downstream drain stage for the weight/input-stationary systolic matmul output. Captures the staggered, double-held per-column outputs of `systolic_matmul_fsm`, reassembles them into complete output-matrix rows, buffers them in a small row FIFO, and streams rows out on a valid/ready interface. It gives the BISR controller and the host readout path one row-ordered stream instead of per-column timing.

---
 rtl/matmul_out_pkg.sv | 21 ++
 rtl/matmul_output_deskew_row_fifo.sv | 47 ++++
 rtl/matmul_output_deskew.sv | 142 ++++++++++++++
 tb/tb_matmul_output_deskew.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/matmul_out_pkg.sv
// Shared sizing, row/tag types and a width helper for the systolic matmul output drain.
package matmul_out_pkg;

   localparam int DEF_WORD       = 16;
   localparam int DEF_ROWS       = 4;
   localparam int DEF_COLS       = 4;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int DEF_ASM_SLOTS  = 4;

   localparam int PTR_W  = $clog2(DEF_FIFO_DEPTH);
   localparam int SLOT_W = $clog2(DEF_ASM_SLOTS);

   typedef logic [DEF_COLS-1:0][DEF_WORD-1:0] row_t;
   typedef logic [$clog2(DEF_ROWS)-1:0]       row_tag_t;

   // Index width that never collapses to zero bits for tiny sizes.
   function automatic int clog2_1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/matmul_output_deskew_row_fifo.sv
// Synchronous FIFO; pop data is the head entry read combinationally, one-cycle push-to-visible.
// Push while full is accepted only together with a pop; rst clears the pointers.
module row_fifo
   import matmul_out_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_dat,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_dat,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = clog2_1(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
   end

endmodule

// File: rtl/matmul_output_deskew.sv
// Reassembles staggered, double-held column outputs into rows and streams them valid/ready.
// Row visible 2 cycles after its last column's input cycle; a full FIFO drops rows, upstream never stalls.
module matmul_output_deskew
   import matmul_out_pkg::*;
#(
   parameter int WORD_SIZE  = DEF_WORD,
   parameter int ROWS       = DEF_ROWS,
   parameter int COLS       = DEF_COLS,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int ASM_SLOTS  = DEF_ASM_SLOTS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [COLS*WORD_SIZE-1:0] matmul_fsm_output,
   input  logic [COLS-1:0]           matmul_output_valid,
   output logic                      row_valid,
   input  logic                      row_ready,
   output logic [COLS*WORD_SIZE-1:0] row_data,
   output logic [$clog2(ROWS)-1:0]   row_index,
   output logic                      last_row,
   output logic                      overflow,
   output logic                      done
);
   localparam int ROW_W = COLS * WORD_SIZE;
   localparam int TAG_W = $clog2(ROWS);
   localparam int CNT_W = clog2_1(ROWS + 1);
   localparam int ASM_W = clog2_1(ASM_SLOTS);
   localparam int ENT_W = TAG_W + ROW_W;

   if (ASM_SLOTS <= (COLS - 1) / 2) begin : g_asm_chk
      $error("ASM_SLOTS must exceed (COLS-1)/2");
   end

   logic                 w_clr;
   logic [COLS-1:0]      r_ph;
   logic [CNT_W-1:0]     r_wcnt [COLS];
   logic [COLS-1:0]      r_mask [ASM_SLOTS];
   logic [WORD_SIZE-1:0] r_slot_dat [ASM_SLOTS][COLS];
   logic [TAG_W-1:0]     r_slot_tag [ASM_SLOTS];
   logic [CNT_W-1:0]     r_pop_cnt;
   logic                 r_overflow;
   logic                 r_done;

   logic [COLS-1:0]      w_smp;
   logic [ASM_W-1:0]     w_slot [COLS];
   logic                 w_cmp_vld;
   logic [ASM_W-1:0]     w_cmp_slot;
   logic [ROW_W-1:0]     w_cmp_row;
   logic [ENT_W-1:0]     w_push_dat;
   logic [ENT_W-1:0]     w_head;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;

   assign w_clr = rst | start;

   // One sample per 2-cycle hold: take the first cycle, skip the repeat.
   always_comb begin
      w_smp = '0;
      for (int c = 0; c < COLS; c++) begin
         w_smp[c]  = matmul_output_valid[c] && !r_ph[c] && (r_wcnt[c] != CNT_W'(ROWS));
         w_slot[c] = ASM_W'(32'(r_wcnt[c]) % ASM_SLOTS);
      end
   end

   always_comb begin
      w_cmp_vld  = 1'b0;
      w_cmp_slot = '0;
      w_cmp_row  = '0;
      for (int s = 0; s < ASM_SLOTS; s++) begin
         if (&r_mask[s]) begin
            w_cmp_vld  = 1'b1;
            w_cmp_slot = ASM_W'(s);
         end
      end
      for (int c = 0; c < COLS; c++) begin
         w_cmp_row[c*WORD_SIZE +: WORD_SIZE] = r_slot_dat[w_cmp_slot][c];
      end
   end

   assign w_pop      = !w_empty && row_ready;
   assign w_push     = w_cmp_vld && (!w_full || w_pop);
   assign w_push_dat = {r_slot_tag[w_cmp_slot], w_cmp_row};

   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_ph       <= '0;
         r_pop_cnt  <= '0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
         for (int c = 0; c < COLS; c++)      r_wcnt[c] <= '0;
         for (int s = 0; s < ASM_SLOTS; s++) r_mask[s] <= '0;
      end else begin
         r_ph <= matmul_output_valid & ~r_ph;
         if (w_cmp_vld) r_mask[w_cmp_slot] <= '0;
         for (int c = 0; c < COLS; c++) begin
            if (w_smp[c]) begin
               r_wcnt[c]            <= r_wcnt[c] + 1'b1;
               r_mask[w_slot[c]][c] <= 1'b1;
            end
         end
         if (w_cmp_vld && !w_push) r_overflow <= 1'b1;
         if (w_pop && (r_pop_cnt != CNT_W'(ROWS))) begin
            r_pop_cnt <= r_pop_cnt + 1'b1;
            if (r_pop_cnt == CNT_W'(ROWS - 1)) r_done <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!w_clr) begin
         for (int c = 0; c < COLS; c++) begin
            if (w_smp[c]) r_slot_dat[w_slot[c]][c] <= matmul_fsm_output[c*WORD_SIZE +: WORD_SIZE];
         end
         if (w_smp[0]) r_slot_tag[w_slot[0]] <= r_wcnt[0][TAG_W-1:0];
      end
   end

   row_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_row_fifo (
      .clk        (clk),
      .rst        (w_clr),
      .i_push     (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .o_pop_dat  (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   assign row_valid = !w_empty;
   assign row_data  = w_empty ? '0 : w_head[ROW_W-1:0];
   assign row_index = w_empty ? '0 : w_head[ENT_W-1:ROW_W];
   assign last_row  = !w_empty && (w_head[ENT_W-1:ROW_W] == TAG_W'(ROWS - 1));
   assign overflow  = r_overflow;
   assign done      = r_done;

endmodule

// File: tb/tb_matmul_output_deskew.sv
// Two drains (FIFO depth 4 and 2) share one staggered input stream; a queue-level model predicts both.
module tb_matmul_output_deskew;
   localparam int C = 4;

   typedef struct packed { logic [1:0] idx; logic [63:0] dat; } ent_t;
   typedef struct packed { logic [1:0] idx; logic [63:0] dat; logic last; } log_t;
   typedef struct { int ord; logic [1:0] idx; logic [63:0] dat; bit last; } vec_t;

   logic        clk = 1'b0;
   logic        rst, start, row_ready;
   logic [63:0] mm_out;
   logic [3:0]  mm_vld;
   logic        o_vld [2];
   logic [63:0] o_dat [2];
   logic [1:0]  o_idx [2];
   logic        o_last [2];
   logic        o_ovf [2];
   logic        o_done [2];

   int   n_chk = 0, n_fail = 0, cyc = 0;
   int   depth [2];
   ent_t mf [2][8];
   int   mn [2], mpops [2];
   bit   movf [2], mdone [2];
   int   pend = -1;
   ent_t pend_ent;
   logic [63:0] rowdat [4];
   log_t plog [$];
   vec_t tbl [4];

   always #5 clk = ~clk;

   matmul_output_deskew #(.WORD_SIZE(16), .ROWS(4), .COLS(4), .FIFO_DEPTH(4), .ASM_SLOTS(4)) dut_a (
      .clk(clk), .rst(rst), .start(start), .matmul_fsm_output(mm_out), .matmul_output_valid(mm_vld),
      .row_valid(o_vld[0]), .row_ready(row_ready), .row_data(o_dat[0]), .row_index(o_idx[0]),
      .last_row(o_last[0]), .overflow(o_ovf[0]), .done(o_done[0]));

   matmul_output_deskew #(.WORD_SIZE(16), .ROWS(4), .COLS(4), .FIFO_DEPTH(2), .ASM_SLOTS(4)) dut_b (
      .clk(clk), .rst(rst), .start(start), .matmul_fsm_output(mm_out), .matmul_output_valid(mm_vld),
      .row_valid(o_vld[1]), .row_ready(row_ready), .row_data(o_dat[1]), .row_index(o_idx[1]),
      .last_row(o_last[1]), .overflow(o_ovf[1]), .done(o_done[1]));

   task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, inst, cyc, act, exp);
      end
   endtask

   // One clock: drive, advance the queue model across the edge, compare both drains.
   task automatic tick(input bit st, input bit rs, input logic [3:0] v, input logic [63:0] d,
                       input bit rdy, input int comp);
      ent_t he;
      bit   popd;
      start = st; rst = rs; mm_vld = v; mm_out = d; row_ready = rdy;
      if (o_vld[0] === 1'b1 && rdy && !st && !rs) plog.push_back({o_idx[0], o_dat[0], o_last[0]});
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (rs || st) begin
            mn[i] = 0; movf[i] = 0; mpops[i] = 0; mdone[i] = 0;
         end else begin
            popd = (mn[i] > 0) && rdy;
            if (popd) begin
               for (int j = 0; j < 7; j++) mf[i][j] = mf[i][j+1];
               mn[i]--;
               mpops[i]++;
               if (mpops[i] == 4) mdone[i] = 1;
            end
            if (pend >= 0) begin
               if (mn[i] < depth[i]) begin
                  mf[i][mn[i]] = pend_ent;
                  mn[i]++;
               end else movf[i] = 1;
            end
         end
      end
      pend = (rs || st) ? -1 : comp;
      if (pend >= 0) begin
         pend_ent.idx = 2'(comp);
         pend_ent.dat = rowdat[comp];
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         he = mf[i][0];
         chk("row_valid", i, 64'(o_vld[i]), 64'(mn[i] > 0));
         chk("row_data",  i, o_dat[i], (mn[i] > 0) ? he.dat : 64'd0);
         chk("row_index", i, 64'(o_idx[i]), (mn[i] > 0) ? 64'(he.idx) : 64'd0);
         chk("last_row",  i, 64'(o_last[i]), 64'((mn[i] > 0) && (he.idx == 2'd3)));
         chk("overflow",  i, 64'(o_ovf[i]), 64'(movf[i]));
         chk("done",      i, 64'(o_done[i]), 64'(mdone[i]));
      end
   endtask

   // mode: 0 ready, 1 random, 2 stall until 3 buffered, 3 stall through all, 4 pop only on completion edges
   // abort_kind: 0 none, 1 start, 2 rst, issued two cycles after row 1 is pushed.
   task automatic run(input int mode, input bit nominal, input int gapmax, input int abort_kind, input bit extra);
      int s [5];
      int len, abort_t, comp;
      logic [3:0]  v;
      logic [63:0] d;
      bit rdy;
      for (int k = 0; k < 4; k++)
         for (int c = 0; c < C; c++)
            rowdat[k][c*16 +: 16] = nominal ? 16'(k*16 + c) : 16'($urandom);
      s[0] = $urandom_range(0, 2);
      for (int k = 1; k < 5; k++) s[k] = s[k-1] + 2 + $urandom_range(0, gapmax);
      len     = s[4] + C + 14;
      abort_t = s[1] + C + 2;
      tick(1, 0, 4'd0, 64'd0, 1, -1);
      for (int t = 0; t < len; t++) begin
         if (abort_kind != 0 && t == abort_t) begin
            tick(abort_kind == 1, abort_kind == 2, 4'd0, 64'd0, 1, -1);
            tick(0, 0, 4'd0, 64'd0, 1, -1);
            return;
         end
         v = '0; d = '0; comp = -1;
         for (int k = 0; k < 5; k++) begin
            if (k < 4 || extra) begin
               for (int c = 0; c < C; c++) begin
                  if (t >= s[k] + c && t <= s[k] + c + 1) begin
                     v[c] = 1'b1;
                     d[c*16 +: 16] = (k < 4) ? rowdat[k][c*16 +: 16] : 16'($urandom);
                  end
               end
            end
            if (k < 4 && t == s[k] + C - 1) comp = k;
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            2:       rdy = (t >= s[2] + C + 1);
            3:       rdy = (t >= s[3] + C + 4);
            default: rdy = (t == s[2] + C) || (t >= s[3] + C);
         endcase
         tick(0, 0, v, d, rdy, comp);
      end
   endtask

   task automatic check_table();
      log_t e;
      chk("pop_count", 0, 64'(plog.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < plog.size()) begin
            e = plog[tbl[i].ord];
            chk("tbl_index", 0, 64'(e.idx), 64'(tbl[i].idx));
            chk("tbl_data",  0, e.dat, tbl[i].dat);
            chk("tbl_last",  0, 64'(e.last), 64'(tbl[i].last));
         end else chk("tbl_missing", 0, 64'(plog.size()), 64'(i + 1));
      end
   endtask

   initial begin
      tbl[0] = '{0, 2'd0, 64'h0003_0002_0001_0000, 1'b0};
      tbl[1] = '{1, 2'd1, 64'h0013_0012_0011_0010, 1'b0};
      tbl[2] = '{2, 2'd2, 64'h0023_0022_0021_0020, 1'b0};
      tbl[3] = '{3, 2'd3, 64'h0033_0032_0031_0030, 1'b1};
      depth[0] = 4; depth[1] = 2;
      for (int i = 0; i < 2; i++) begin
         mn[i] = 0; mpops[i] = 0; movf[i] = 0; mdone[i] = 0;
      end

      tick(0, 1, 4'd0, 64'd0, 1, -1);
      tick(0, 1, 4'd0, 64'd0, 1, -1);

      plog.delete();
      run(0, 1, 0, 0, 0);
      check_table();

      run(2, 1, 0, 0, 0);

      run(3, 0, 1, 0, 0);
      chk("ovf_depth2_set", 1, 64'(o_ovf[1]), 64'd1);
      chk("done_depth2_low", 1, 64'(o_done[1]), 64'd0);
      chk("done_depth4", 0, 64'(o_done[0]), 64'd1);

      run(4, 0, 1, 0, 0);
      chk("full_pop_no_ovf", 1, 64'(o_ovf[1]), 64'd0);
      chk("full_pop_done", 1, 64'(o_done[1]), 64'd1);

      run(1, 0, 1, 1, 0);
      chk("start_flush", 0, 64'(o_vld[0]), 64'd0);
      plog.delete();
      run(0, 1, 1, 0, 0);
      check_table();

      run(1, 0, 2, 2, 0);
      chk("rst_clears_data", 0, o_dat[0], 64'd0);
      chk("rst_clears_ovf", 1, 64'(o_ovf[1]), 64'd0);

      run(0, 0, 0, 0, 1);

      for (int r = 0; r < 10; r++) run(1, 0, 3, 0, 1'($urandom_range(0, 1)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
